gray_pulse_regen: RTL and testbench
===================================

GRAY_PULSE_REGEN -- requirements
Module: gray_pulse_regen

Interface
REQ-001 Parameter: PULSE_HIGH, 2, pulse_out high time in clk cycles (range 1..255).
REQ-002 Parameter: PULSE_LOW, 2, minimum pulse_out low time between pulses in clk cycles (range 1..255).
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: ui_in  input  8  Gray-coded count from a remote pulse counter; asynchronous to clk.
REQ-006 Port: uo_out  output  8  [0] pulse_out, [1] busy, [2] overflow (sticky), [7:3] pending level (min(pending,31)).

Function
REQ-007 The block SHALL be the receiving end of a Gray pulse counter: it SHALL regenerate one output pulse per increment of the received count.
REQ-008 ui_in SHALL pass through a 2-flop synchronizer (s1, s2) before any use.
REQ-009 s2 SHALL be decoded Gray-to-binary combinationally: bin[7]=s2[7]; bin[i]=bin[i+1] XOR s2[i] for i=6..0.
REQ-010 Register prev_bin (8 bit) SHALL load bin every cycle; delta SHALL be (bin - prev_bin) mod 256.
REQ-011 Warm-up: for the first 3 rising edges after reset release delta SHALL be forced to 0 (prev_bin still loads); accumulation SHALL start on the 4th edge.
REQ-012 Pending counter (8 bit) SHALL update as pending + delta - dec each cycle, dec=1 when the FSM launches a pulse that cycle, else 0.
REQ-013 If pending + delta - dec exceeds 255, pending SHALL saturate at 255 and overflow SHALL set and remain 1 until reset.
REQ-014 Simultaneous delta and dec in one cycle SHALL both be applied; no increment or launch SHALL be lost below saturation.
REQ-015 FSM states: IDLE, HIGH, LOW; 8-bit phase timer.
REQ-016 IDLE: if pending != 0, go to HIGH, assert dec, timer=PULSE_HIGH-1; else stay.
REQ-017 HIGH: timer decrements; at timer=0 go to LOW with timer=PULSE_LOW-1.
REQ-018 LOW: timer decrements; at timer=0, if pending != 0 go directly to HIGH (assert dec, reload PULSE_HIGH-1), else go to IDLE.
REQ-019 pulse_out SHALL be 1 exactly when state=HIGH (registered, glitch-free); pulse period under backlog SHALL be PULSE_HIGH+PULSE_LOW cycles.
REQ-020 busy SHALL be 1 when state != IDLE or pending != 0.
REQ-021 Latency: ui_in stable before edge E0 with a +1 change SHALL give pending increment at E2 and pulse_out high after E3 (from IDLE, post-warm-up).
REQ-022 Count wrap 255->0 at the source SHALL yield delta=1 (one pulse), by the modulo rule.
REQ-023 A decreasing count SHALL be treated as a large modulo-256 forward delta (no special case).

Reset
REQ-024 rst_n low SHALL immediately clear s1, s2, prev_bin, pending, timer, warm-up counter and overflow, and force state IDLE, regardless of clock.
REQ-025 During reset uo_out SHALL be 8'h00; reset mid-pulse SHALL drop pulse_out to 0 without completing the pulse.
REQ-026 After reset release, the value present on ui_in SHALL NOT generate pulses (warm-up absorbs it).

Verification
REQ-027 Reset with ui_in=8'h00, release, step ui_in through Gray codes of 1..5 (one change per 20 cycles), defaults -> exactly 5 pulses, each 2 cycles high, first pulse_out high 4 edges after first change.
REQ-028 Hold ui_in=Gray(200) through reset release -> no pulses, busy=0, pending field 0 after warm-up.
REQ-029 Jump ui_in from Gray(10) to Gray(50) in one step -> pending 40, uo_out[7:3]=31, busy=1, 40 pulses at 4-cycle period, then busy=0.
REQ-030 Step 254->255->0->1 -> exactly 3 pulses (wrap counted).
REQ-031 Jump 0->255 then 255->254 (delta 255) before draining -> pending saturates 255, overflow=1, sticky until rst_n low.
REQ-032 Assert rst_n low while pulse_out=1 with pending=10 -> uo_out=8'h00 immediately, no pulses after release until ui_in changes.

Source files
------------

// File: rtl/gray_pulse_regen.sv
// gray_pulse_regen: receiving end of a Gray-coded pulse counter.
// The asynchronous Gray count is synchronised, decoded to binary and differenced
// against the previous sample. Each increment is banked in a saturating pending
// counter, which a three-state FSM drains by emitting fixed-width pulses.
module gray_pulse_regen #(
  parameter int PULSE_HIGH = 2,
  parameter int PULSE_LOW  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam logic [7:0] PH_LOAD = 8'(PULSE_HIGH - 1);
  localparam logic [7:0] PL_LOAD = 8'(PULSE_LOW - 1);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [7:0] s1_q, s2_q;
  logic [7:0] prev_bin_q;
  logic [1:0] warm_q, warm_d;
  logic [7:0] pending_q, pending_d;
  logic       ovf_q, ovf_d;
  logic [7:0] timer_q, timer_d;
  state_e     state_q, state_d;
  logic [7:0] uo_q, uo_d;

  logic [7:0] bin_s;
  logic [7:0] delta_s;
  logic       dec_s;
  logic [8:0] sum_s;
  logic [4:0] lvl_s;
  logic       busy_s;

  assign bin_s = gray2bin(s2_q);

  // Two-flop synchroniser for the asynchronous Gray count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 8'h00;
      s2_q <= 8'h00;
    end else begin
      s1_q <= ui_in;
      s2_q <= s1_q;
    end
  end

  // Warm-up: the first three edges after reset only prime prev_bin, so the
  // count sitting on ui_in at release never turns into pulses.
  always_comb begin
    warm_d  = (warm_q == 2'd3) ? warm_q : (warm_q + 2'd1);
    delta_s = (warm_q == 2'd3) ? (bin_s - prev_bin_q) : 8'h00;
  end

  // Pulse FSM: launch from IDLE, hold HIGH, enforce LOW gap, chain under backlog.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dec_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != 8'h00) begin
          state_d = ST_HIGH;
          timer_d = PH_LOAD;
          dec_s   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (timer_q == 8'h00) begin
          state_d = ST_LOW;
          timer_d = PL_LOAD;
        end else begin
          timer_d = timer_q - 8'h01;
        end
      end
      ST_LOW: begin
        if (timer_q == 8'h00) begin
          if (pending_q != 8'h00) begin
            state_d = ST_HIGH;
            timer_d = PH_LOAD;
            dec_s   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 8'h01;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = 8'h00;
      end
    endcase
  end

  // Pending bank: add the new increments and retire a launch in the same cycle;
  // anything beyond 255 saturates and latches overflow until reset.
  always_comb begin
    sum_s = {1'b0, pending_q} + {1'b0, delta_s} - {8'h00, dec_s};
    if (sum_s[8]) begin
      pending_d = 8'hFF;
      ovf_d     = 1'b1;
    end else begin
      pending_d = sum_s[7:0];
      ovf_d     = ovf_q;
    end
  end

  // Output word built from next-state values so the registered copy lines up
  // with the state it describes.
  always_comb begin
    lvl_s  = (pending_d > 8'd31) ? 5'd31 : pending_d[4:0];
    busy_s = (state_d != ST_IDLE) || (pending_d != 8'h00);
    uo_d   = {lvl_s, ovf_d, busy_s, (state_d == ST_HIGH)};
  end

  // Core state registers; async reset clears everything, including the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_bin_q <= 8'h00;
      warm_q     <= 2'd0;
      pending_q  <= 8'h00;
      ovf_q      <= 1'b0;
      timer_q    <= 8'h00;
      state_q    <= ST_IDLE;
      uo_q       <= 8'h00;
    end else begin
      prev_bin_q <= bin_s;
      warm_q     <= warm_d;
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
      uo_q       <= uo_d;
    end
  end

  assign uo_out = uo_q;

endmodule

// File: tb/tb_gray_pulse_regen.sv
// Directed bench for gray_pulse_regen with default pulse timing (2 high, 2 low).
module tb_gray_pulse_regen;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int compared   = 0;
  int mismatched = 0;

  // Monitor statistics (monotonic; test steps take differences).
  int cyc        = 0;
  int pulse_cnt  = 0;
  int gap4_cnt   = 0;
  int width_err  = 0;
  int run_len    = 0;
  int last_rise  = -100;
  logic prev_pulse = 1'b0;

  int base_p, base_g, base_w;

  gray_pulse_regen #(.PULSE_HIGH(2), .PULSE_LOW(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge: counts pulses, 4-cycle gaps and bad widths.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      run_len = 0;
    end else if (uo_out[0]) begin
      if (!prev_pulse) begin
        pulse_cnt = pulse_cnt + 1;
        if (cyc - last_rise == 4) gap4_cnt = gap4_cnt + 1;
        last_rise = cyc;
      end
      run_len = run_len + 1;
    end else begin
      if (run_len != 0 && run_len != 2) width_err = width_err + 1;
      run_len = 0;
    end
    prev_pulse = rst_n ? uo_out[0] : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared = compared + 1;
    assert (obs === exp) else begin
      mismatched = mismatched + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] val);
    rst_n = 1'b0;
    ui_in = val;
    #2;
    check("reset_uo", {24'h0, uo_out}, 32'h0);
    cycles(3);
    rst_n = 1'b1;
    cycles(10);
  endtask

  initial begin
    rst_n = 1'b0;
    ui_in = 8'h00;
    #2;
    check("por_uo", {24'h0, uo_out}, 32'h0);
    cycles(3);
    rst_n = 1'b1;
    cycles(10);
    check("post_warmup_uo", {24'h0, uo_out}, 32'h0);

    // Gray(1..5) one step per 20 cycles: five 2-cycle pulses, first at E3.
    base_p = pulse_cnt; base_w = width_err;
    ui_in = 8'h01;
    cycles(2);
    check("lat_e1", {24'h0, uo_out}, 32'h00);
    cycles(1);
    check("lat_e2", {24'h0, uo_out}, 32'h0A);
    cycles(1);
    check("lat_e3", {24'h0, uo_out}, 32'h03);
    cycles(16);
    ui_in = 8'h03; cycles(20);
    ui_in = 8'h02; cycles(20);
    ui_in = 8'h06; cycles(20);
    ui_in = 8'h07; cycles(20);
    check("seq5_pulses", pulse_cnt - base_p, 32'd5);
    check("seq5_width", width_err - base_w, 32'd0);
    check("seq5_idle", {24'h0, uo_out}, 32'h0);

    // Gray(200) held through reset release: nothing generated.
    base_p = pulse_cnt;
    do_reset(8'hAC);
    cycles(10);
    check("hold200_uo", {24'h0, uo_out}, 32'h0);
    check("hold200_pulses", pulse_cnt - base_p, 32'd0);

    // Jump Gray(10) -> Gray(50): 40 pulses at a 4-cycle period.
    do_reset(8'h0F);
    base_p = pulse_cnt; base_g = gap4_cnt; base_w = width_err;
    ui_in = 8'h2B;
    cycles(3);
    check("jump40_e2", {24'h0, uo_out}, 32'hFA);
    cycles(200);
    check("jump40_pulses", pulse_cnt - base_p, 32'd40);
    check("jump40_period", gap4_cnt - base_g, 32'd39);
    check("jump40_width", width_err - base_w, 32'd0);
    check("jump40_idle", {24'h0, uo_out}, 32'h0);

    // Wrap 254 -> 255 -> 0 -> 1: three pulses.
    do_reset(8'h81);
    base_p = pulse_cnt;
    ui_in = 8'h80; cycles(20);
    ui_in = 8'h00; cycles(20);
    ui_in = 8'h01; cycles(20);
    check("wrap_pulses", pulse_cnt - base_p, 32'd3);
    check("wrap_idle", {24'h0, uo_out}, 32'h0);

    // 0 -> 255 then 255 -> 254: saturation and sticky overflow.
    do_reset(8'h00);
    ui_in = 8'h80;
    cycles(3);
    check("sat_first", {24'h0, uo_out}, 32'hFA);
    cycles(2);
    ui_in = 8'h81;
    cycles(3);
    check("sat_ovf", {25'h0, uo_out[7:1]}, 32'h7F);
    cycles(100);
    check("sat_sticky", {31'h0, uo_out[2]}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("sat_reset_uo", {24'h0, uo_out}, 32'h0);
    cycles(3);
    rst_n = 1'b1;
    cycles(10);
    check("sat_cleared", {24'h0, uo_out}, 32'h0);

    // Reset mid-pulse with a backlog: output clears at once, no pulses after.
    do_reset(8'h00);
    ui_in = 8'h0F;
    cycles(3);
    check("mid_e2", {24'h0, uo_out}, 32'h52);
    cycles(1);
    check("mid_high", {24'h0, uo_out}, 32'h4B);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_uo", {24'h0, uo_out}, 32'h0);
    base_p = pulse_cnt;
    cycles(3);
    rst_n = 1'b1;
    cycles(40);
    check("mid_no_pulses", pulse_cnt - base_p, 32'd0);
    check("mid_idle", {24'h0, uo_out}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
